// File: rtl/fml_vtx_capture.sv
// Retirement-record capture for the formal instruction checkers: one record per
// CPU->COP instruction, with register snapshots and up to NMEM memory transactions.
module fml_vtx_capture #(
    parameter int NMEM = 4
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  cpu_insn_req,
    input  logic                  cpu_insn_ack,
    input  logic [31:0]           cpu_insn_enc,
    input  logic [31:0]           cpu_rs1,
    input  logic [31:0]           cpu_rs2,
    input  logic                  cop_insn_ack,
    input  logic                  cop_insn_rsp,
    input  logic [2:0]            cop_result,
    input  logic                  cop_wen,
    input  logic [4:0]            cop_waddr,
    input  logic [31:0]           cop_wdata,
    input  logic                  cop_mem_cen,
    input  logic                  cop_mem_wen,
    input  logic                  cop_mem_stall,
    input  logic [31:0]           cop_mem_addr,
    input  logic [31:0]           cop_mem_wdata,
    input  logic [3:0]            cop_mem_ben,
    input  logic [31:0]           cop_mem_rdata,
    input  logic                  cop_mem_error,
    input  logic [511:0]          cprs_flat,
    input  logic [31:0]           rand_sample,
    output logic                  vtx_reset,
    output logic                  vtx_valid,
    output logic [31:0]           vtx_instr_enc,
    output logic [31:0]           vtx_instr_rs1,
    output logic [31:0]           vtx_instr_rs2,
    output logic [31:0]           vtx_instr_wdata,
    output logic [31:0]           vtx_rand_sample,
    output logic [2:0]            vtx_instr_result,
    output logic [4:0]            vtx_instr_waddr,
    output logic                  vtx_instr_wen,
    output logic [511:0]          vtx_cprs_pre_flat,
    output logic [511:0]          vtx_cprs_post_flat,
    output logic [NMEM-1:0]       vtx_mem_cen,
    output logic [NMEM-1:0]       vtx_mem_wen,
    output logic [NMEM-1:0]       vtx_mem_error,
    output logic [32*NMEM-1:0]    vtx_mem_addr,
    output logic [32*NMEM-1:0]    vtx_mem_wdata,
    output logic [32*NMEM-1:0]    vtx_mem_rdata,
    output logic [4*NMEM-1:0]     vtx_mem_ben,
    output logic                  vtx_proto_err,
    output logic                  vtx_mem_ovf
);

    localparam int SW = $clog2(NMEM);
    localparam int CW = $clog2(NMEM + 1);
    localparam logic [CW-1:0] SLOTS = CW'(NMEM);

    typedef enum logic [1:0] {IDLE, BUSY, POST} state_t;

    state_t        state;
    logic [CW-1:0] mem_count;
    logic          rsp_pending;
    logic [SW-1:0] rsp_slot;

    logic          issue;
    logic          complete;
    logic          accept;
    logic          starting;
    logic          finish;
    logic          fill;
    logic [SW-1:0] fill_slot;
    logic          proto_set;
    logic          ovf_set;

    assign issue    = cpu_insn_req && cpu_insn_ack;
    assign complete = cop_insn_ack && cop_insn_rsp;
    assign accept   = cop_mem_cen && !cop_mem_stall;
    assign starting = issue && (state != BUSY);
    assign finish   = complete && ((state == BUSY) || starting);

    assign vtx_valid          = (state == POST);
    assign vtx_cprs_post_flat = vtx_valid ? cprs_flat : '0;

    // A request accepted on the completion edge cannot be tied to this record,
    // so it is dropped and flagged rather than stored.
    always_comb begin
        fill      = 1'b0;
        fill_slot = '0;
        proto_set = 1'b0;
        ovf_set   = 1'b0;
        if (accept && !complete) begin
            if (starting) begin
                fill = 1'b1;
            end else if (state == BUSY) begin
                if (mem_count < SLOTS) begin
                    fill      = 1'b1;
                    fill_slot = mem_count[SW-1:0];
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
        if ((state == BUSY) && issue)
            proto_set = 1'b1;
        if ((state == IDLE) && !issue && (complete || accept))
            proto_set = 1'b1;
        if (accept && complete && ((state == BUSY) || starting))
            proto_set = 1'b1;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state             <= IDLE;
            vtx_reset         <= 1'b1;
            mem_count         <= '0;
            rsp_pending       <= 1'b0;
            rsp_slot          <= '0;
            vtx_instr_enc     <= '0;
            vtx_instr_rs1     <= '0;
            vtx_instr_rs2     <= '0;
            vtx_instr_wdata   <= '0;
            vtx_rand_sample   <= '0;
            vtx_instr_result  <= '0;
            vtx_instr_waddr   <= '0;
            vtx_instr_wen     <= 1'b0;
            vtx_cprs_pre_flat <= '0;
            vtx_mem_cen       <= '0;
            vtx_mem_wen       <= '0;
            vtx_mem_error     <= '0;
            vtx_mem_addr      <= '0;
            vtx_mem_wdata     <= '0;
            vtx_mem_rdata     <= '0;
            vtx_mem_ben       <= '0;
            vtx_proto_err     <= 1'b0;
            vtx_mem_ovf       <= 1'b0;
        end else begin
            vtx_reset   <= 1'b0;
            rsp_pending <= 1'b0;
            if (proto_set)
                vtx_proto_err <= 1'b1;
            if (ovf_set)
                vtx_mem_ovf <= 1'b1;

            if (rsp_pending) begin
                vtx_mem_rdata[32*rsp_slot +: 32] <= cop_mem_rdata;
                vtx_mem_error[rsp_slot]          <= cop_mem_error;
            end

            if (starting) begin
                vtx_instr_enc     <= cpu_insn_enc;
                vtx_instr_rs1     <= cpu_rs1;
                vtx_instr_rs2     <= cpu_rs2;
                vtx_rand_sample   <= rand_sample;
                vtx_cprs_pre_flat <= cprs_flat;
                vtx_mem_cen       <= '0;
                vtx_mem_wen       <= '0;
                vtx_mem_error     <= '0;
                vtx_mem_addr      <= '0;
                vtx_mem_wdata     <= '0;
                vtx_mem_rdata     <= '0;
                vtx_mem_ben       <= '0;
                mem_count         <= '0;
                state             <= complete ? POST : BUSY;
            end else if (state == BUSY) begin
                state <= complete ? POST : BUSY;
            end else begin
                state <= IDLE;
            end

            if (finish) begin
                vtx_instr_result <= cop_result;
                vtx_instr_wen    <= cop_wen;
                vtx_instr_waddr  <= cop_waddr;
                vtx_instr_wdata  <= cop_wdata;
            end

            // Placed after the issue-time clear so a request accepted with the
            // issue lands in slot 0 of the new record.
            if (fill) begin
                vtx_mem_cen[fill_slot]            <= 1'b1;
                vtx_mem_wen[fill_slot]            <= cop_mem_wen;
                vtx_mem_addr[32*fill_slot +: 32]  <= cop_mem_addr;
                vtx_mem_wdata[32*fill_slot +: 32] <= cop_mem_wdata;
                vtx_mem_ben[4*fill_slot +: 4]     <= cop_mem_ben;
                mem_count                         <= starting ? CW'(1) : mem_count + CW'(1);
                rsp_pending                       <= 1'b1;
                rsp_slot                          <= fill_slot;
            end
        end
    end

endmodule

// File: doc/fml_vtx_capture.md
# fml_vtx_capture

Trace-capture stage feeding the formal instruction checkers. Watches the CPU→COP instruction handshake, COP response handshake, COP memory bus and COP register file, and assembles one retirement record per instruction. Presents the record for exactly one cycle with `vtx_valid`, including pre/post register snapshots and up to four memory transactions.

## Interface
- `NMEM`, 4: memory-transaction slots per instruction; fixed at 4 for checker port compatibility.
- `g_clk` in 1: sole clock.
- `g_resetn` in 1: asynchronous, active-low reset.
- `cpu_insn_req`, `cpu_insn_ack` in 1 each: issue handshake; issue = both high.
- `cpu_insn_enc`, `cpu_rs1`, `cpu_rs2` in 32 each: encoding and GPR operands at issue.
- `cop_insn_ack`, `cop_insn_rsp` in 1 each: completion handshake; complete = both high.
- `cop_result` in 3, `cop_wen` in 1, `cop_waddr` in 5, `cop_wdata` in 32: response fields at completion.
- `cop_mem_cen`, `cop_mem_wen` in 1 each; `cop_mem_stall` in 1; `cop_mem_addr`, `cop_mem_wdata` in 32 each; `cop_mem_ben` in 4: request; accepted = `cen && !stall`.
- `cop_mem_rdata` in 32, `cop_mem_error` in 1: response, valid the cycle after acceptance.
- `cprs_flat` in 512: live COP registers, reg i at [32i+31:32i].
- `rand_sample` in 32: free-running random word.
- `vtx_reset` out 1: high in reset and the first cycle after release.
- `vtx_valid` out 1: record-valid pulse.
- `vtx_instr_enc`, `vtx_instr_rs1`, `vtx_instr_rs2`, `vtx_instr_wdata`, `vtx_rand_sample` out 32 each; `vtx_instr_result` out 3; `vtx_instr_waddr` out 5; `vtx_instr_wen` out 1.
- `vtx_cprs_pre_flat`, `vtx_cprs_post_flat` out 512: snapshots, same packing as `cprs_flat`.
- `vtx_mem_cen`, `vtx_mem_wen`, `vtx_mem_error` out 4; `vtx_mem_addr`, `vtx_mem_wdata`, `vtx_mem_rdata` out 128; `vtx_mem_ben` out 16: slot i at bit i / [32i+31:32i] / [4i+3:4i].
- `vtx_proto_err`, `vtx_mem_ovf` out 1 each: sticky error flags.

## Operation
- States: IDLE, BUSY, POST. Reset → IDLE.
- IDLE: issue → latch enc, rs1, rs2, `rand_sample`, `cprs_flat` into pre; clear all slots (cen=0, counter=0); → BUSY, or → POST if complete in the same cycle.
- BUSY: complete → latch result, wen, waddr, wdata; → POST.
- POST: `vtx_valid`=1 (decoded from state); `vtx_cprs_post_flat` = live `cprs_flat` this cycle (COP writes landed on completion edge). Issue here → latch as in IDLE, → BUSY (or POST if also complete); else → IDLE.
- Memory: acceptance in BUSY, or at issue in IDLE/POST, fills slot[counter] (cen=1, wen, addr, wdata, ben); counter+1. Next cycle writes rdata/error into that slot.
- Response arriving in the completion cycle is included. A request accepted in the completion cycle sets `vtx_proto_err` and is dropped.
- 5th acceptance in one instruction: set `vtx_mem_ovf`, drop it; counter saturates at 4.
- Issue in BUSY, completion in IDLE, or acceptance in IDLE without issue: set `vtx_proto_err`, otherwise ignored.
- Sticky flags clear only on reset.

## Timing
- Reset: all outputs 0 except `vtx_reset`=1. State IDLE, counter 0.
- `vtx_reset` clears on the first rising edge after `g_resetn` deasserts.
- `vtx_valid` is exactly one cycle, the cycle after the completion handshake. Minimum issue-to-valid is 1 cycle (same-cycle issue+complete).
- Record outputs hold stable from capture until the next issue edge. Post-snapshot is valid only while `vtx_valid`=1.
- Back-to-back: issue in the POST cycle gives no bubble; the next valid can come 1 cycle later.
- Reset mid-instruction: record discarded, no `vtx_valid`.

## Test plan
- Issue enc=0x0000_400B, rs1=5, rs2=7; complete 3 cycles later with result=1, wen=1, waddr=3, wdata=0xC -> `vtx_valid` one cycle after completion, fields match, pre=regs at issue.
- COP writes reg 2 := 0xDEAD at completion -> `vtx_cprs_post_flat`[95:64]=0xDEAD, pre unchanged.
- Two accepted loads (addr 0x100, 0x104; rdata 0xAA, 0xBB), one stalled 2 cycles -> `vtx_mem_cen`=4'b0011, slot data correct.
- Five accepted requests in one instruction -> `vtx_mem_ovf`=1, slots 0..3 hold the first four.
- Issue in the POST cycle, complete 1 cycle later -> two `vtx_valid` pulses 2 cycles apart with distinct records.
- Assert `g_resetn`=0 in BUSY -> all outputs 0 asynchronously, `vtx_reset`=1; no `vtx_valid` after release.
